// File: rtl/kmeans_assign_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_assign_scheduler_pkg
// Description : Shared widths, state encodings and k clamp for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package kmeans_assign_scheduler_pkg;

    localparam int N_W   = 16;
    localparam int C_W   = 5;
    localparam int MAX_K = 32;
    localparam int K_W   = 6;
    localparam int D_W   = 10;
    localparam int ST_W  = 4;

    localparam logic [K_W-1:0] K_MAX = K_W'(MAX_K);

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_LATCH     = 4'd1;
    localparam state_t ST_PT_CHECK  = 4'd2;
    localparam state_t ST_MIN_START = 4'd3;
    localparam state_t ST_MIN_WAIT  = 4'd4;
    localparam state_t ST_MIN_ACK   = 4'd5;
    localparam state_t ST_ASG_READ  = 4'd6;
    localparam state_t ST_ASG_WAIT  = 4'd7;
    localparam state_t ST_ASG_WRITE = 4'd8;
    localparam state_t ST_NEXT      = 4'd9;
    localparam state_t ST_DONE      = 4'd10;
    localparam state_t ST_DONE_WAIT = 4'd11;

    function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kmeans_assign_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_assign_scheduler_if
// Description : Handshake and point-window bus between scheduler and min unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface kmeans_assign_scheduler_if #(
    parameter int N_W = kmeans_assign_scheduler_pkg::N_W,
    parameter int C_W = kmeans_assign_scheduler_pkg::C_W
);
    import kmeans_assign_scheduler_pkg::*;

    logic             min_start;
    logic             min_ack;
    logic             min_stb;
    logic [C_W-1:0]   min_out;
    logic [K_W-1:0]   min_k;
    logic [D_W-1:0]   min_dim;
    logic [N_W-1:0]   point_index;

    modport master (
        output min_start, min_ack, min_k, min_dim, point_index,
        input  min_stb, min_out
    );

    modport slave (
        input  min_start, min_ack, min_k, min_dim, point_index,
        output min_stb, min_out
    );

endinterface
`default_nettype wire

// File: rtl/kmeans_assign_scheduler_count_file.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_assign_scheduler_count_file
// Description : Per-cluster membership counters with clear, indexed increment
//               and a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_assign_scheduler_count_file #(
    parameter int N_W = kmeans_assign_scheduler_pkg::N_W,
    parameter int C_W = kmeans_assign_scheduler_pkg::C_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_i,
    input  logic           inc_i,
    input  logic [C_W-1:0] inc_idx_i,
    input  logic [C_W-1:0] sel_i,
    output logic [N_W-1:0] cnt_o
);
    import kmeans_assign_scheduler_pkg::*;

    logic [N_W-1:0] cnt_w [MAX_K];

    generate
        for (genvar g = 0; g < MAX_K; g++) begin : g_cnt
            logic [N_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (inc_i && (inc_idx_i == C_W'(g))) begin
                    cnt_q <= cnt_q + N_W'(1);
                end
            end

            assign cnt_w[g] = cnt_q;
        end
    endgenerate

    assign cnt_o = cnt_w[sel_i];

endmodule
`default_nettype wire

// File: rtl/kmeans_assign_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_assign_scheduler
// Description : Walks every point through the min unit for one k-means
//               assignment pass, updating assignments, counts and changes.
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_assign_scheduler #(
    parameter int N_W = kmeans_assign_scheduler_pkg::N_W,
    parameter int C_W = kmeans_assign_scheduler_pkg::C_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start_i,
    input  logic                                      ack_i,
    input  logic                                      first_pass_i,
    input  logic [kmeans_assign_scheduler_pkg::K_W-1:0] k_i,
    input  logic [kmeans_assign_scheduler_pkg::D_W-1:0] dim_i,
    input  logic [N_W-1:0]                            n_points_i,
    output logic                                      stb_o,
    output logic [N_W-1:0]                            changes_o,
    kmeans_assign_scheduler_if.master                 min_if,
    output logic [N_W-1:0]                            asg_address_o,
    output logic [C_W-1:0]                            asg_write_data_o,
    output logic                                      asg_write_enable_o,
    input  logic [C_W-1:0]                            asg_read_data_i,
    input  logic [C_W-1:0]                            count_sel_i,
    output logic [N_W-1:0]                            count_out_o
);
    import kmeans_assign_scheduler_pkg::*;

    state_t         state_q;
    state_t         state_d;

    logic [K_W-1:0] min_k_q;
    logic [D_W-1:0] dim_q;
    logic [N_W-1:0] n_q;
    logic           first_q;
    logic [N_W-1:0] idx_q;
    logic [N_W-1:0] addr_q;
    logic [C_W-1:0] wdata_q;
    logic [C_W-1:0] result_q;
    logic [N_W-1:0] changes_q;

    logic           cnt_clr;
    logic           cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_i) state_d = ST_LATCH;
            ST_LATCH:     state_d = ((min_k_q == '0) || (n_q == '0)) ? ST_DONE : ST_PT_CHECK;
            // Hold off the next min_start until the min unit has dropped its strobe.
            ST_PT_CHECK: begin
                if (idx_q >= n_q)        state_d = ST_DONE;
                else if (!min_if.min_stb) state_d = ST_MIN_START;
            end
            ST_MIN_START: state_d = ST_MIN_WAIT;
            ST_MIN_WAIT:  if (min_if.min_stb) state_d = ST_MIN_ACK;
            ST_MIN_ACK:   state_d = ST_ASG_READ;
            ST_ASG_READ:  state_d = ST_ASG_WAIT;
            ST_ASG_WAIT:  state_d = ST_ASG_WRITE;
            ST_ASG_WRITE: state_d = ST_NEXT;
            ST_NEXT:      state_d = ST_PT_CHECK;
            ST_DONE:      state_d = ST_DONE_WAIT;
            ST_DONE_WAIT: if (ack_i) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stb_o              = 1'b0;
        min_if.min_start   = 1'b0;
        min_if.min_ack     = 1'b0;
        asg_write_enable_o = 1'b0;
        cnt_clr            = 1'b0;
        cnt_inc            = 1'b0;
        case (state_q)
            ST_LATCH:     cnt_clr            = 1'b1;
            ST_MIN_START: min_if.min_start   = 1'b1;
            ST_MIN_ACK:   min_if.min_ack     = 1'b1;
            ST_ASG_WRITE: begin
                asg_write_enable_o = 1'b1;
                cnt_inc            = 1'b1;
            end
            ST_DONE_WAIT: stb_o              = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_k_q   <= '0;
            dim_q     <= '0;
            n_q       <= '0;
            first_q   <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            result_q  <= '0;
            changes_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                min_k_q <= clamp_k(k_i);
                dim_q   <= dim_i;
                n_q     <= n_points_i;
                first_q <= first_pass_i;
            end
            if (state_q == ST_LATCH) begin
                idx_q     <= '0;
                changes_q <= '0;
            end
            if ((state_q == ST_MIN_WAIT) && min_if.min_stb) begin
                result_q <= min_if.min_out;
            end
            // Address and data are set up ahead so they are stable through read and write.
            if (state_q == ST_MIN_ACK) begin
                addr_q  <= idx_q;
                wdata_q <= result_q;
            end
            if ((state_q == ST_ASG_WRITE) && (first_q || (asg_read_data_i != result_q))) begin
                changes_q <= changes_q + N_W'(1);
            end
            if (state_q == ST_NEXT) begin
                idx_q <= idx_q + N_W'(1);
            end
        end
    end

    assign changes_o          = changes_q;
    assign asg_address_o      = addr_q;
    assign asg_write_data_o   = wdata_q;
    assign min_if.point_index = idx_q;
    assign min_if.min_k       = min_k_q;
    assign min_if.min_dim     = dim_q;

    kmeans_assign_scheduler_count_file #(
        .N_W (N_W),
        .C_W (C_W)
    ) u_count_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .inc_idx_i (result_q),
        .sel_i     (count_sel_i),
        .cnt_o     (count_out_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_kmeans_assign_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmeans_assign_scheduler
// Description : Directed bench with a min-unit responder and assignment memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmeans_assign_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        first_pass_i = 1'b0;
    logic [5:0]  k_i = '0;
    logic [9:0]  dim_i = '0;
    logic [15:0] n_points_i = '0;
    logic        stb_o;
    logic [15:0] changes_o;
    logic [15:0] asg_address_o;
    logic [4:0]  asg_write_data_o;
    logic        asg_write_enable_o;
    logic [4:0]  asg_read_data_i;
    logic [4:0]  count_sel_i = '0;
    logic [15:0] count_out_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kmeans_assign_scheduler_if #(.N_W(16), .C_W(5)) mif ();

    kmeans_assign_scheduler #(.N_W(16), .C_W(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .ack_i              (ack_i),
        .first_pass_i       (first_pass_i),
        .k_i                (k_i),
        .dim_i              (dim_i),
        .n_points_i         (n_points_i),
        .stb_o              (stb_o),
        .changes_o          (changes_o),
        .min_if             (mif.master),
        .asg_address_o      (asg_address_o),
        .asg_write_data_o   (asg_write_data_o),
        .asg_write_enable_o (asg_write_enable_o),
        .asg_read_data_i    (asg_read_data_i),
        .count_sel_i        (count_sel_i),
        .count_out_o        (count_out_o)
    );

    // Assignment memory: one-cycle synchronous read, read-before-write.
    logic [4:0] mem     [16];
    logic [4:0] pre_val [16];
    logic       pre_en = 1'b0;
    int         wr_total = 0;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= pre_val[i];
        end else if (asg_write_enable_o) begin
            mem[asg_address_o[3:0]] <= asg_write_data_o;
            wr_total <= wr_total + 1;
        end
        asg_read_data_i <= mem[asg_address_o[3:0]];
    end

    // Min-unit responder: strobe mdelay+1 cycles after min_start, drop on min_ack.
    logic [4:0] mvals [64];
    int mdelay = 0;
    int mptr = 0;
    int cyc = 0, ms_total = 0, ma_total = 0, stb_total = 0;
    int stb_cyc = 0, ack_cyc = 0;

    initial begin
        int  cnt;
        bit  pending;
        cnt = 0;
        pending = 0;
        mif.min_stb = 1'b0;
        mif.min_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mif.min_start) ms_total++;
            if (mif.min_ack)   ma_total++;
            if (stb_o)         stb_total++;
            if (!rst_n) begin
                mif.min_stb = 1'b0;
                pending = 0;
            end else if (mif.min_start) begin
                pending = 1;
                cnt = mdelay;
            end else if (pending) begin
                if (cnt == 0) begin
                    mif.min_stb = 1'b1;
                    mif.min_out = mvals[mptr];
                    mptr++;
                    pending = 0;
                    stb_cyc = cyc;
                end else begin
                    cnt--;
                end
            end else if (mif.min_stb && mif.min_ack) begin
                mif.min_stb = 1'b0;
                ack_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2, input logic [4:0] rest);
        for (int i = 0; i < 16; i++) pre_val[i] = rest;
        pre_val[0] = v0;
        pre_val[1] = v1;
        pre_val[2] = v2;
        @(negedge clk);
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic start_pass(input logic [5:0] kk, input logic [9:0] dd, input logic [15:0] nn, input logic fp);
        @(negedge clk);
        k_i = kk;
        dim_i = dd;
        n_points_i = nn;
        first_pass_i = fp;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_stb(input int bound, output int n, output bit ok);
        n = 0;
        ok = 0;
        while (!ok && n < bound) begin
            if (stb_o === 1'b1) ok = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({stb_o, mif.min_start, mif.min_ack, asg_write_enable_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000", {stb_o, mif.min_start, mif.min_ack, asg_write_enable_o});
        end
        checks++;
        if ({changes_o, mif.point_index, asg_address_o} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters: changes=%0d idx=%0d addr=%0d want 0", changes_o, mif.point_index, asg_address_o);
        end
        checks++;
        if (asg_write_data_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_wdata: got %0d want 0", asg_write_data_o);
        end
        for (int c = 0; c < 32; c += 31) begin
            count_sel_i = 5'(c);
            #1;
            checks++;
            if (count_out_o !== 16'd0) begin
                errors++;
                $display("FAIL reset_count%0d: got %0d want 0", c, count_out_o);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_pass();
        int base, ms0, wr0, n;
        bit ok;
        int exp_c [4];
        exp_c = '{1, 0, 2, 0};
        base = mptr;
        mvals[base] = 5'd2; mvals[base+1] = 5'd0; mvals[base+2] = 5'd2;
        mdelay = 3;
        preload(5'd7, 5'd7, 5'd7, 5'd7);
        ms0 = ms_total; wr0 = wr_total;
        start_pass(6'd4, 10'd20, 16'd3, 1'b1);
        checks++;
        if (mif.min_k !== 6'd4 || mif.min_dim !== 10'd20) begin
            errors++;
            $display("FAIL fp_latch: min_k=%0d min_dim=%0d want 4 20", mif.min_k, mif.min_dim);
        end
        wait_stb(500, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fp_stb_timeout: stb=%b want 1 within 500 cycles", stb_o);
        end
        checks++;
        if (changes_o !== 16'd3) begin
            errors++;
            $display("FAIL fp_changes: got %0d want 3", changes_o);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== {5'd2, 5'd0, 5'd2, 5'd7}) begin
            errors++;
            $display("FAIL fp_mem: got %0d %0d %0d %0d want 2 0 2 7", mem[0], mem[1], mem[2], mem[3]);
        end
        for (int c = 0; c < 4; c++) begin
            count_sel_i = 5'(c);
            #1;
            checks++;
            if (count_out_o !== 16'(exp_c[c])) begin
                errors++;
                $display("FAIL fp_count%0d: got %0d want %0d", c, count_out_o, exp_c[c]);
            end
        end
        checks++;
        if (ms_total - ms0 != 3 || wr_total - wr0 != 3) begin
            errors++;
            $display("FAIL fp_txn_counts: min_start cycles=%0d writes=%0d want 3 3", ms_total - ms0, wr_total - wr0);
        end
        checks++;
        if (mif.point_index !== 16'd3) begin
            errors++;
            $display("FAIL fp_point_index: got %0d want 3", mif.point_index);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stb_o !== 1'b1) begin
            errors++;
            $display("FAIL fp_stb_held: got %b want 1", stb_o);
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        checks++;
        if (stb_o !== 1'b0 || changes_o !== 16'd3) begin
            errors++;
            $display("FAIL fp_after_ack: stb=%b changes=%0d want 0 3", stb_o, changes_o);
        end
    endtask

    task automatic test_second_pass();
        int base, n;
        bit ok;
        int exp_c [4];
        exp_c = '{0, 1, 2, 0};
        base = mptr;
        mvals[base] = 5'd2; mvals[base+1] = 5'd1; mvals[base+2] = 5'd2;
        mdelay = 1;
        start_pass(6'd4, 10'd20, 16'd3, 1'b0);
        wait_stb(500, n, ok);
        checks++;
        if (!ok || changes_o !== 16'd1) begin
            errors++;
            $display("FAIL sp_changes: stb=%b changes=%0d want 1 1", stb_o, changes_o);
        end
        checks++;
        if ({mem[0], mem[1], mem[2]} !== {5'd2, 5'd1, 5'd2}) begin
            errors++;
            $display("FAIL sp_mem: got %0d %0d %0d want 2 1 2", mem[0], mem[1], mem[2]);
        end
        for (int c = 0; c < 4; c++) begin
            count_sel_i = 5'(c);
            #1;
            checks++;
            if (count_out_o !== 16'(exp_c[c])) begin
                errors++;
                $display("FAIL sp_count%0d: got %0d want %0d", c, count_out_o, exp_c[c]);
            end
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    task automatic test_empty();
        int ms0, n;
        bit ok;
        logic [5:0]  tk [2];
        logic [15:0] tn [2];
        tk = '{6'd4, 6'd0};
        tn = '{16'd0, 16'd3};
        for (int t = 0; t < 2; t++) begin
            ms0 = ms_total;
            start_pass(tk[t], 10'd5, tn[t], 1'b1);
            wait_stb(10, n, ok);
            checks++;
            if (!ok || n > 2) begin
                errors++;
                $display("FAIL empty%0d_latency: stb=%b cycles=%0d want stb within 2", t, stb_o, n);
            end
            checks++;
            if (ms_total != ms0 || changes_o !== 16'd0) begin
                errors++;
                $display("FAIL empty%0d_idle: min_start cycles=%0d changes=%0d want 0 0", t, ms_total - ms0, changes_o);
            end
            count_sel_i = 5'd2;
            #1;
            checks++;
            if (count_out_o !== 16'd0) begin
                errors++;
                $display("FAIL empty%0d_count2: got %0d want 0", t, count_out_o);
            end
            ack_i = 1'b1;
            @(negedge clk);
            ack_i = 1'b0;
        end
    endtask

    task automatic test_clamp_delay();
        int base, ms0, ma0, n;
        bit ok;
        base = mptr;
        mvals[base] = 5'd31;
        mdelay = 50;
        ms0 = ms_total; ma0 = ma_total;
        start_pass(6'd40, 10'h3FF, 16'd1, 1'b1);
        checks++;
        if (mif.min_k !== 6'd32 || mif.min_dim !== 10'h3FF) begin
            errors++;
            $display("FAIL clamp_min_k: min_k=%0d min_dim=%0d want 32 1023", mif.min_k, mif.min_dim);
        end
        wait_stb(500, n, ok);
        checks++;
        if (!ok || ms_total - ms0 != 1 || ma_total - ma0 != 1) begin
            errors++;
            $display("FAIL clamp_pulses: stb=%b start cycles=%0d ack cycles=%0d want 1 1 1", stb_o, ms_total - ms0, ma_total - ma0);
        end
        checks++;
        if (ack_cyc - stb_cyc != 1) begin
            errors++;
            $display("FAIL clamp_ack_timing: ack %0d cycles after strobe, want 1", ack_cyc - stb_cyc);
        end
        count_sel_i = 5'd31;
        #1;
        checks++;
        if (mem[0] !== 5'd31 || count_out_o !== 16'd1 || changes_o !== 16'd1) begin
            errors++;
            $display("FAIL clamp_result: mem0=%0d count31=%0d changes=%0d want 31 1 1", mem[0], count_out_o, changes_o);
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base, ms0, n;
        bit ok;
        base = mptr;
        mvals[base] = 5'd3; mvals[base+1] = 5'd5; mvals[base+2] = 5'd6;
        mdelay = 20;
        preload(5'd0, 5'd0, 5'd0, 5'd0);
        ms0 = ms_total;
        start_pass(6'd8, 10'd7, 16'd3, 1'b1);
        n = 0;
        while (ms_total - ms0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        count_sel_i = 5'd3;
        #1;
        checks++;
        if (changes_o !== 16'd1 || mif.point_index !== 16'd1 || count_out_o !== 16'd1) begin
            errors++;
            $display("FAIL rm_before: changes=%0d idx=%0d count3=%0d want 1 1 1", changes_o, mif.point_index, count_out_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stb_o, mif.min_start, mif.min_ack, asg_write_enable_o} !== 4'b0000 || changes_o !== 16'd0) begin
            errors++;
            $display("FAIL rm_strobes: strobes=%b changes=%0d want 0000 0", {stb_o, mif.min_start, mif.min_ack, asg_write_enable_o}, changes_o);
        end
        checks++;
        if (mif.point_index !== 16'd0 || asg_write_data_o !== 5'd0 || count_out_o !== 16'd0 || mif.min_k !== 6'd0) begin
            errors++;
            $display("FAIL rm_regs: idx=%0d wdata=%0d count3=%0d min_k=%0d want 0", mif.point_index, asg_write_data_o, count_out_o, mif.min_k);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = mptr;
        mvals[base] = 5'd1; mvals[base+1] = 5'd0;
        mdelay = 2;
        preload(5'd1, 5'd1, 5'd0, 5'd0);
        start_pass(6'd4, 10'd7, 16'd2, 1'b0);
        wait_stb(500, n, ok);
        count_sel_i = 5'd0;
        #1;
        checks++;
        if (!ok || changes_o !== 16'd1 || count_out_o !== 16'd1 || {mem[0], mem[1]} !== {5'd1, 5'd0}) begin
            errors++;
            $display("FAIL rm_rerun: stb=%b changes=%0d count0=%0d mem=%0d %0d want 1 1 1 1 0", stb_o, changes_o, count_out_o, mem[0], mem[1]);
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    task automatic test_start_ignored();
        int base, ms0, st0, n;
        bit ok;
        base = mptr;
        mvals[base] = 5'd1; mvals[base+1] = 5'd1;
        mdelay = 10;
        ms0 = ms_total;
        start_pass(6'd4, 10'd3, 16'd2, 1'b1);
        ack_i = 1'b1;
        repeat (5) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        st0 = stb_total;
        wait_stb(500, n, ok);
        repeat (5) @(negedge clk);
        count_sel_i = 5'd1;
        #1;
        checks++;
        if (!ok || stb_total - st0 != 1 || stb_o !== 1'b0) begin
            errors++;
            $display("FAIL si_stb_pulse: seen=%b stb cycles=%0d stb=%b want 1 1 0", ok, stb_total - st0, stb_o);
        end
        checks++;
        if (ms_total - ms0 != 2 || changes_o !== 16'd2 || count_out_o !== 16'd2) begin
            errors++;
            $display("FAIL si_pass: min_start cycles=%0d changes=%0d count1=%0d want 2 2 2", ms_total - ms0, changes_o, count_out_o);
        end
        ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_second_pass();
        test_empty();
        test_clamp_delay();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kmeans_assign_scheduler.md
Name: kmeans_assign_scheduler

Overview:
Sequences the nearest-centroid (min) unit over every point of a data set for one k-means assignment pass. Per point: presents the point index, runs one start/stb/ack transaction with the min unit, and read-modify-writes the result into an external assignment memory. Tracks per-cluster membership counts and the number of changed assignments for the update/convergence logic. Sits between the top-level iteration controller and the min unit.

Parameters:
N_W, 16, width of point count/index and of all counters
C_W, 5, width of cluster index (max 32 clusters)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin pass; sampled only in IDLE
ack  in  1  host acknowledges done strobe
first_pass  in  1  latched at start; 1 = stored assignments invalid, every point counts as changed
k  in  6  cluster count, latched at start
dim  in  10  dimensions, latched at start, passed through
n_points  in  N_W  points in set, latched at start
stb  out  1  pass complete, held until ack
changes  out  N_W  changed assignments in last pass
min_start  out  1  start to min unit
min_ack  out  1  ack to min unit
min_stb  in  1  min unit result valid
min_out  in  C_W  nearest cluster index
min_k  out  6  k to min unit (clamped)
min_dim  out  10  dim to min unit
point_index  out  N_W  current point; selects min unit's point window
asg_address  out  N_W  assignment memory address
asg_write_data  out  C_W  assignment write data
asg_write_enable  out  1  assignment write strobe
asg_read_data  in  C_W  assignment read data, 1-cycle read latency
count_sel  in  C_W  cluster count read select
count_out  out  N_W  combinational read of count[count_sel]

Behaviour:
- Reset (async, low): state IDLE; stb, min_start, min_ack, asg_write_enable = 0; changes, point_index, asg_address, asg_write_data = 0; all 32 counts = 0.
- States: IDLE, LATCH, PT_CHECK, MIN_START, MIN_WAIT, MIN_ACK, ASG_READ, ASG_WAIT, ASG_WRITE, NEXT, DONE, DONE_WAIT.
- IDLE: start=1 -> LATCH. Start in any other state ignored.
- LATCH: latch k, dim, n_points, first_pass; clear counts and changes; point_index=0; min_k = (k>32) ? 32 : k. If k==0 or n_points==0 -> DONE (changes=0, counts 0).
- PT_CHECK: point_index<n_points -> MIN_START, else DONE.
- MIN_START: min_start=1 exactly one cycle -> MIN_WAIT.
- MIN_WAIT: wait min_stb=1; capture min_out into result reg -> MIN_ACK. No timeout.
- MIN_ACK: min_ack=1 one cycle. Must not reassert min_start until min_stb observed low -> ASG_READ.
- ASG_READ: asg_address=point_index (read) -> ASG_WAIT (1 cycle) -> ASG_WRITE.
- ASG_WRITE: asg_write_data=result, asg_write_enable=1 one cycle; count[result]+=1; changes+=1 if first_pass or asg_read_data!=result -> NEXT.
- NEXT: point_index+=1 -> PT_CHECK.
- DONE: stb=1 -> DONE_WAIT; ack=1 -> stb=0, IDLE. changes and counts hold until next start.
- Widths: counters N_W, cannot overflow (bounded by n_points); point_index wraps never (loop ends at n_points). min_out>=min_k is written as-is, no check.
- Per-point cost: min latency + 6 cycles.
- Reset mid-pass: immediate IDLE; min unit reset by the same global reset; assignment memory contents undefined for that pass.

Decomposition:
- Shared package: state encodings, N_W, C_W, MAX_K=32.
- Natural sub-module: cluster_count_file (32 x N_W registers, clear, increment-by-index, combinational read port).

Test Plan:
- k=4, n_points=3, first_pass=1, min model returns 2,0,2 -> asg writes addr0=2, addr1=0, addr2=2; changes=3; count[2]=2, count[0]=1; stb until ack.
- Same set, first_pass=0, memory holds 2,0,2, model returns 2,1,2 -> changes=1; count[1]=1, count[2]=2.
- n_points=0 or k=0 -> stb within 3 cycles of start, no min_start, changes=0.
- k=40 -> min_k=32; min model stb delayed 50 cycles -> min_start exactly 1 cycle, min_ack 1 cycle after capture.
- Reset low during MIN_WAIT -> all outputs zero immediately; new start runs cleanly.
- Start pulsed during pass and ack held high across DONE -> start ignored; stb one cycle then IDLE.
